div_seq: RTL and testbench

- Parametrised sequential restoring divider: 2W-bit dividend by W-bit divisor, giving a W-bit quotient and a W-bit remainder.
- Successor to the fixed 64/32 divider. Adds:
  - width parameter
  - per-operation signed/unsigned mode
  - start/ready/done handshake
  - divide-by-zero and overflow detection
  - asynchronous reset
- Sits beside the ALU as a multi-cycle execution unit.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_seq_if.sv | 30 +++
 rtl/addsub_w.sv | 13 +
 rtl/div_seq.sv | 193 +++++++++++++++++++
 tb/tb_div_seq.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Width of a counter that must hold 0..w-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// Start/ready/done handshake and operand/result bus of the divider.
interface div_seq_if
  import div_pkg::*;
#(
  parameter int unsigned W = DIV_W_DEFAULT
) ();

  logic           start;
  logic           signed_mode;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           ready;
  logic           busy;
  logic           done;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_zero;
  logic           overflow;

  modport master (
    output start, signed_mode, dividend, divisor,
    input  ready, busy, done, quotient, remainder, div_zero, overflow
  );

  modport slave (
    input  start, signed_mode, dividend, divisor,
    output ready, busy, done, quotient, remainder, div_zero, overflow
  );

endinterface

// File: rtl/addsub_w.sv
// N-bit subtractor a - b with borrow out, used for the restoring trial step.
module addsub_w #(
  parameter int unsigned N = 33
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_diff,
  output logic         o_borrow
);

  assign {o_borrow, o_diff} = {1'b0, i_a} - {1'b0, i_b};

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, signed or
// unsigned per operation, one quotient bit per cycle.
module div_seq
  import div_pkg::*;
#(
  parameter int unsigned W = DIV_W_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  div_seq_if.slave bus
);

  localparam int unsigned  W2      = 2 * W;
  localparam int unsigned  CW      = cnt_width(W);
  localparam logic [W-1:0] MSB_ONE = {1'b1, {(W-1){1'b0}}};

  div_state_e    r_state, w_state_n;
  logic [W2-1:0] r_acc,   w_acc_n;
  logic [W-1:0]  r_dvs,   w_dvs_n;
  logic [CW-1:0] r_cnt,   w_cnt_n;
  logic          r_smode, w_smode_n;
  logic          r_sq,    w_sq_n;
  logic          r_sr,    w_sr_n;

  logic          r_ready, w_ready_n;
  logic          r_busy,  w_busy_n;
  logic          r_done,  w_done_n;
  logic [W-1:0]  r_quot,  w_quot_n;
  logic [W-1:0]  r_rem,   w_rem_n;
  logic          r_dz,    w_dz_n;
  logic          r_ovf,   w_ovf_n;

  // Operand magnitudes and result signs, evaluated on the accept edge.
  logic          w_dvd_neg, w_dvs_neg;
  logic [W2-1:0] w_dvd_abs;
  logic [W-1:0]  w_dvs_abs;
  logic          w_hi_ge;

  assign w_dvd_neg = bus.signed_mode & bus.dividend[W2-1];
  assign w_dvs_neg = bus.signed_mode & bus.divisor[W-1];
  assign w_dvd_abs = w_dvd_neg ? (~bus.dividend + W2'(1)) : bus.dividend;
  assign w_dvs_abs = w_dvs_neg ? (~bus.divisor + W'(1)) : bus.divisor;
  assign w_hi_ge   = (w_dvd_abs[W2-1:W] >= w_dvs_abs);

  // Trial subtraction of the divisor from the shifted partial remainder.
  logic [W:0] w_top, w_diff;
  logic       w_borrow, w_neg;

  assign w_top = r_acc[W2-1:W-1];

  addsub_w #(.N(W + 1)) u_sub (
    .i_a      (w_top),
    .i_b      ({1'b0, r_dvs}),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  // The difference lies in [-d, d), so its MSB agrees with the borrow.
  assign w_neg = w_borrow | w_diff[W];

  // Sign application and signed range check on the finished magnitudes.
  logic [W-1:0] w_qmag, w_rmag, w_qlim;
  logic         w_sovf;

  assign w_qmag = r_acc[W-1:0];
  assign w_rmag = r_acc[W2-1:W];
  assign w_qlim = r_sq ? MSB_ONE : (MSB_ONE - W'(1));
  assign w_sovf = r_smode & (w_qmag > w_qlim);

  always_comb begin
    w_state_n = r_state;
    w_acc_n   = r_acc;
    w_dvs_n   = r_dvs;
    w_cnt_n   = r_cnt;
    w_smode_n = r_smode;
    w_sq_n    = r_sq;
    w_sr_n    = r_sr;
    w_quot_n  = r_quot;
    w_rem_n   = r_rem;
    w_dz_n    = r_dz;
    w_ovf_n   = r_ovf;

    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_acc_n   = w_dvd_abs;
          w_dvs_n   = w_dvs_abs;
          w_smode_n = bus.signed_mode;
          w_sq_n    = w_dvd_neg ^ w_dvs_neg;
          w_sr_n    = w_dvd_neg;
          w_cnt_n   = '0;
          if (bus.divisor == '0) begin
            w_dz_n    = 1'b1;
            w_ovf_n   = 1'b0;
            w_quot_n  = '1;
            w_rem_n   = bus.dividend[W-1:0];
            w_state_n = DONE;
          end else if (w_hi_ge) begin
            w_dz_n    = 1'b0;
            w_ovf_n   = 1'b1;
            w_quot_n  = '0;
            w_rem_n   = '0;
            w_state_n = DONE;
          end else begin
            w_dz_n    = 1'b0;
            w_ovf_n   = 1'b0;
            w_state_n = CALC;
          end
        end
      end

      CALC: begin
        if (w_neg) begin
          w_acc_n = {r_acc[W2-2:0], 1'b0};
        end else begin
          w_acc_n = {w_diff[W-1:0], r_acc[W-2:0], 1'b1};
        end
        w_cnt_n = r_cnt + CW'(1);
        if (r_cnt == CW'(W - 1)) begin
          w_state_n = FIX;
        end
      end

      FIX: begin
        if (w_sovf) begin
          w_ovf_n  = 1'b1;
          w_quot_n = '0;
          w_rem_n  = '0;
        end else begin
          w_quot_n = r_sq ? (~w_qmag + W'(1)) : w_qmag;
          w_rem_n  = r_sr ? (~w_rmag + W'(1)) : w_rmag;
        end
        w_state_n = DONE;
      end

      DONE: begin
        w_state_n = IDLE;
      end

      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  // Handshake outputs follow the next state; done trails the DONE state by one edge.
  assign w_ready_n = (w_state_n == IDLE);
  assign w_busy_n  = (w_state_n == CALC) || (w_state_n == FIX);
  assign w_done_n  = (r_state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_smode <= 1'b0;
      r_sq    <= 1'b0;
      r_sr    <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_acc   <= w_acc_n;
      r_dvs   <= w_dvs_n;
      r_cnt   <= w_cnt_n;
      r_smode <= w_smode_n;
      r_sq    <= w_sq_n;
      r_sr    <= w_sr_n;
      r_ready <= w_ready_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
      r_quot  <= w_quot_n;
      r_rem   <= w_rem_n;
      r_dz    <= w_dz_n;
      r_ovf   <= w_ovf_n;
    end
  end

  assign bus.ready     = r_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.quotient  = r_quot;
  assign bus.remainder = r_rem;
  assign bus.div_zero  = r_dz;
  assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_div_seq.sv
// Directed and randomised checks of div_seq at W=32 against hand-computed values.
module tb_div_seq;

  localparam int unsigned W = 32;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  div_seq_if #(.W(W)) bus ();

  div_seq #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Issue one operation and return the number of edges from accept to done.
  task automatic run_op(input logic sm, input logic [63:0] dvd, input logic [31:0] dvs,
                        output int lat);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.signed_mode = sm;
    bus.dividend    = dvd;
    bus.divisor     = dvs;
    @(posedge clk);
    #1;
    bus.start       = 1'b0;
    bus.signed_mode = ~sm;
    bus.dividend    = ~dvd;
    bus.divisor     = ~dvs;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_op(input string tag, input logic sm, input logic [63:0] dvd,
                          input logic [31:0] dvs, input int exp_lat,
                          input logic [31:0] eq, input logic [31:0] er,
                          input logic edz, input logic eovf);
    int lat;
    run_op(sm, dvd, dvs, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_q"},   64'(bus.quotient),  64'(eq));
    chk({tag, "_r"},   64'(bus.remainder), 64'(er));
    chk({tag, "_flags"}, 64'({bus.div_zero, bus.overflow}), 64'({edz, eovf}));
    @(posedge clk);
    #1;
    chk({tag, "_done_width"}, 64'(bus.done), 64'(0));
  endtask

  initial begin
    int          lat;
    int          acc0, acc1, bad;
    bit          got1, saw_done;
    logic [31:0] q1, r1;

    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.signed_mode = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.ready), 64'(1));
    chk("rst_busy_done", 64'({bus.busy, bus.done}), 64'(0));
    chk("rst_qr", {bus.quotient, bus.remainder}, 64'(0));
    chk("rst_flags", 64'({bus.div_zero, bus.overflow}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    check_op("u100_7", 1'b0, 64'd100, 32'd7, 34, 32'd14, 32'd2, 1'b0, 1'b0);
    check_op("s_m100_7", 1'b1, 64'hFFFFFFFF_FFFFFF9C, 32'd7, 34,
             32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0);
    check_op("s_min_1", 1'b1, 64'hFFFFFFFF_80000000, 32'd1, 34,
             32'h80000000, 32'h0, 1'b0, 1'b0);
    check_op("divzero", 1'b0, 64'd5, 32'd0, 1, 32'hFFFFFFFF, 32'd5, 1'b1, 1'b0);
    check_op("u_ovf", 1'b0, 64'h00000001_00000000, 32'd1, 1, 32'h0, 32'h0, 1'b0, 1'b1);
    check_op("s_ovf", 1'b1, 64'h00000000_80000000, 32'd1, 34, 32'h0, 32'h0, 1'b0, 1'b1);
    check_op("s_m7_m2", 1'b1, 64'hFFFFFFFF_FFFFFFF9, 32'hFFFFFFFE, 34,
             32'd3, 32'hFFFFFFFF, 1'b0, 1'b0);

    // Abort an operation with reset ten cycles after accept.
    @(negedge clk);
    bus.start = 1'b1;
    bus.signed_mode = 1'b0;
    bus.dividend = 64'd1000;
    bus.divisor = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("calc_busy_ready", 64'({bus.busy, bus.ready}), 64'(2'b10));
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_ready", 64'(bus.ready), 64'(1));
    chk("abort_outs", {bus.quotient, bus.remainder}, 64'(0));
    chk("abort_ctl", 64'({bus.busy, bus.done, bus.div_zero, bus.overflow}), 64'(0));
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    chk("abort_no_done", 64'(saw_done), 64'(0));

    check_op("u_max_ovf", 1'b0, 64'hFFFFFFFF_FFFFFFFF, 32'hFFFFFFFF, 1,
             32'h0, 32'h0, 1'b0, 1'b1);
    check_op("u_max", 1'b0, 64'hFFFFFFFE_FFFFFFFF, 32'hFFFFFFFF, 34,
             32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);

    // Back-to-back with start held high; operand changes while busy.
    acc0 = -1;
    acc1 = -1;
    got1 = 1'b0;
    q1 = '0;
    r1 = '0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.signed_mode = 1'b0;
    bus.dividend = 64'd100;
    bus.divisor = 32'd7;
    for (int c = 0; c < 120; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.done === 1'b1 && !got1) begin
        got1 = 1'b1;
        q1 = bus.quotient;
        r1 = bus.remainder;
      end
      if (bus.ready === 1'b1 && bus.start === 1'b1) begin
        if (acc0 < 0) acc0 = c;
        else if (acc1 < 0) acc1 = c;
      end
      @(posedge clk);
      #1;
      if (acc1 >= 0) begin
        bus.start = 1'b0;
        bus.dividend = 64'd9;
        bus.divisor = 32'd0;
      end else if (acc0 >= 0) begin
        bus.dividend = 64'd1000;
        bus.divisor = 32'd3;
      end
    end
    chk("b2b_interval", 64'(acc1 - acc0), 64'(35));
    chk("b2b_first", {q1, r1}, {32'd14, 32'd2});
    chk("b2b_second", {bus.quotient, bus.remainder}, {32'd333, 32'd1});

    // Random non-error operations against a 64-bit arithmetic reference.
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      logic [63:0] dvd, eqr, tq, tr;
      logic [31:0] d, q, r;
      int          ia, ib;
      longint      sa, sb;
      if ((i % 2) == 0) begin
        d = $urandom;
        if (d == 32'd0) d = 32'd1;
        q = $urandom;
        r = $urandom % d;
        dvd = 64'(q) * 64'(d) + 64'(r);
        eqr = {q, r};
        run_op(1'b0, dvd, d, lat);
      end else begin
        ia = $urandom;
        ib = $urandom;
        if (ib == 0) ib = 1;
        if (ia == 32'sh80000000 && ib == -1) ib = 1;
        sa = ia;
        sb = ib;
        tq = sa / sb;
        tr = sa % sb;
        eqr = {tq[31:0], tr[31:0]};
        dvd = sa;
        d = ib;
        run_op(1'b1, dvd, d, lat);
      end
      if (lat != 34 || bus.div_zero !== 1'b0 || bus.overflow !== 1'b0) bad++;
      chk($sformatf("rnd%0d", i), {bus.quotient, bus.remainder}, eqr);
    end
    chk("rnd_lat_flags", 64'(bad), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
